// File: rtl/bin2bcd8_fmt.sv
// bin2bcd8_fmt: sequential double-dabble binary to 8-digit BCD with blanking, overflow and dp mask
module bin2bcd8_fmt #(
  parameter int BIN_W = 27,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  input  logic [7:0]       dp_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       d0,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4,
  output logic [3:0]       d5,
  output logic [3:0]       d6,
  output logic [3:0]       d7,
  output logic [7:0]       dp_mask
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [4:0] LAST = 5'(BIN_W - 1);
  state_t state, state_n;
  logic [BIN_W-1:0] bin;
  logic [31:0] acc, adj, fmt, dq;
  logic [4:0] cnt;
  logic [7:0] dp_l;
  logic ovf, keep;
  assign busy = state != IDLE;
  assign {d7, d6, d5, d4, d3, d2, d1, d0} = dq;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: one pass IDLE -> SHIFT (BIN_W bits) -> COMMIT -> IDLE
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? SHIFT :
              (state == SHIFT && cnt == LAST) ? COMMIT :
              (state == COMMIT) ? IDLE : state;
  end
  // add-3 correction on every nibble before the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < 8; i++)
      adj[4*i+:4] = (acc[4*i+:4] >= 4'd5) ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
  end
  // display formatting: overflow shows all E; a nonzero digit or set dp keeps itself and everything below
  always_comb begin
    fmt = '1;
    keep = !BLANK_LZ;
    for (int i = 7; i >= 0; i--) begin
      keep = keep | (acc[4*i+:4] != 4'd0) | dp_l[i] | (i == 0);
      fmt[4*i+:4] = ovf ? 4'hE : (keep ? acc[4*i+:4] : 4'hF);
    end
  end
  // datapath: latch on start, shift one bit per cycle, publish only at commit
  always_ff @(posedge clk)
    if (rst) begin
      bin <= '0;
      acc <= '0;
      cnt <= '0;
      dp_l <= '0;
      ovf <= 1'b0;
      dq <= '1;
      dp_mask <= '0;
      done <= 1'b0;
    end else begin
      done <= state == COMMIT;
      if (state == IDLE && start) begin
        bin <= bin_in;
        acc <= '0;
        cnt <= '0;
        dp_l <= dp_in;
        ovf <= 27'(bin_in) > 27'd99_999_999;
      end
      if (state == SHIFT) begin
        acc <= {adj[30:0], bin[BIN_W-1]};
        bin <= bin << 1;
        cnt <= cnt + 5'd1;
      end
      if (state == COMMIT) begin
        dq <= fmt;
        dp_mask <= ovf ? 8'h00 : dp_l;
      end
    end
endmodule

// File: tb/tb_bin2bcd8_fmt.sv
// tb_bin2bcd8_fmt: directed and random checks of bin2bcd8_fmt against an arithmetic decimal model
module tb_bin2bcd8_fmt;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [26:0] bin_in = '0;
  logic [7:0] dp_in = '0;
  logic busy, done, busy_b, done_b;
  logic [3:0] a0, a1, a2, a3, a4, a5, a6, a7, b0, b1, b2, b3, b4, b5, b6, b7;
  logic [7:0] dpm_a, dpm_b;
  logic [31:0] dig_a, dig_b;
  int n_cmp = 0, n_err = 0;
  assign dig_a = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign dig_b = {b7, b6, b5, b4, b3, b2, b1, b0};
  always #5 clk = ~clk;

  bin2bcd8_fmt #(.BIN_W(27), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .dp_in(dp_in),
    .busy(busy), .done(done), .d0(a0), .d1(a1), .d2(a2), .d3(a3),
    .d4(a4), .d5(a5), .d6(a6), .d7(a7), .dp_mask(dpm_a));

  bin2bcd8_fmt #(.BIN_W(27), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .dp_in(dp_in),
    .busy(busy_b), .done(done_b), .d0(b0), .d1(b1), .d2(b2), .d3(b3),
    .d4(b4), .d5(b5), .d6(b6), .d7(b7), .dp_mask(dpm_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] model(input logic [26:0] v, input logic [7:0] dp, input bit blank);
    int unsigned r = v;
    logic [3:0] dg [8];
    logic [31:0] o = '0;
    bit vis = !blank;
    if (v > 27'd99_999_999) return {8'h00, 32'hEEEE_EEEE};
    for (int i = 0; i < 8; i++) begin
      dg[i] = 4'(r % 10);
      r = r / 10;
    end
    for (int i = 7; i >= 0; i--) begin
      vis = vis || dg[i] != 4'd0 || dp[i] || i == 0;
      o[4*i+:4] = vis ? dg[i] : 4'hF;
    end
    return {dp, o};
  endfunction

  task automatic convert(input logic [26:0] v, input logic [7:0] dp, input int inj);
    int cyc = 0, nbusy = 0;
    bit stable = 1'b1;
    logic [47:0] prev;
    logic [39:0] ea, eb;
    ea = model(v, dp, 1'b1);
    eb = model(v, dp, 1'b0);
    @(negedge clk);
    prev = {dpm_a, dig_a, 8'h00};
    bin_in = v;
    dp_in = dp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin_in = 27'($urandom);
    dp_in = 8'($urandom);
    if (busy === 1'b1) nbusy++;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == inj) begin
        start = 1'b1;
        bin_in = 27'd5678;
      end
      if (busy === 1'b1) nbusy++;
      if (done !== 1'b1 && {dpm_a, dig_a, 8'h00} !== prev) stable = 1'b0;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'd28);
    chk("busy_len", 64'(nbusy), 64'd28);
    chk("stable_during_shift", 64'(stable), 64'd1);
    chk("digits_blank", 64'(dig_a), 64'(ea[31:0]));
    chk("dp_blank", 64'(dpm_a), 64'(ea[39:32]));
    chk("digits_noblank", 64'(dig_b), 64'(eb[31:0]));
    chk("dp_noblank", 64'(dpm_b), 64'(eb[39:32]));
  endtask

  task automatic idle_after;
    @(posedge clk);
    #1;
    chk("done_single", 64'(done), 64'd0);
    chk("no_requeue_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    logic [26:0] v;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_digits", 64'(dig_a), 64'hFFFF_FFFF);
    chk("rst_dp", 64'(dpm_a), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    convert(27'd12_345_678, 8'h00, -1);
    chk("t1_digits", 64'(dig_a), 64'h1234_5678);
    idle_after();
    convert(27'd0, 8'h00, -1);
    chk("t2_zero", 64'(dig_a), 64'hFFFF_FFF0);
    convert(27'd5, 8'h04, -1);
    chk("t2_dp", 64'(dig_a), 64'hFFFF_F005);
    chk("t2_dpmask", 64'(dpm_a), 64'h04);
    convert(27'd99_999_999, 8'h00, -1);
    chk("t3_max", 64'(dig_a), 64'h9999_9999);
    convert(27'd100_000_000, 8'hFF, -1);
    chk("t3_ovf", 64'(dig_a), 64'hEEEE_EEEE);
    chk("t3_ovf_dp", 64'(dpm_a), 64'h00);
    convert(27'd1234, 8'h00, 10);
    chk("t4_ignored_start", 64'(dig_a), 64'hFFFF_1234);
    idle_after();
    convert(27'd777, 8'h00, 27);
    idle_after();
    convert(27'd4321, 8'h00, -1);
    @(negedge clk);
    bin_in = 27'd8765;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_rst_digits", 64'(dig_a), 64'hFFFF_FFFF);
    chk("t5_rst_dp", 64'(dpm_a), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    chk("t5_no_done", 64'(seen), 64'd0);
    convert(27'd42, 8'h00, -1);
    chk("t6_noblank", 64'(dig_b), 64'h0000_0042);
    convert(27'd31, 8'h10, -1);
    convert(27'd9_000_001, 8'h00, -1);
    for (int i = 0; i < 12; i++) begin
      v = (i % 3 == 0) ? 27'(99_999_990 + $urandom_range(0, 20)) : 27'($urandom_range(0, 134_217_727));
      if (i % 4 == 1) v = 27'($urandom_range(0, 9999));
      convert(v, 8'($urandom), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
